tlb_lookup_ctrl: RTL and testbench
==================================

# tlb_lookup_ctrl

Fully-associative instruction/data TLB front-end that translates 32-bit virtual addresses to physical addresses on 4 KiB pages. It sits directly upstream of `tlb_miss`. On a miss it raises `tlb_miss_detected` with the faulting virtual address, stalls new requests, and waits for `tlb_update` plus the physical address produced by `tlb_miss`. It then installs the entry and completes the stalled request. Hits return in one cycle.

## Interface
- `ENTRIES`, 4: number of TLB entries; power of two, ≥2.
- `ADDR_WIDTH`, 32: virtual/physical address width.
- `PAGE_OFFSET_BITS`, 12: page offset width; VPN/PPN = upper `ADDR_WIDTH-PAGE_OFFSET_BITS` bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  translation request.
- `req_ready`  out  1  block accepts a request this cycle.
- `virtual_address`  in  32  address to translate; sampled when `req_valid && req_ready`.
- `resp_valid`  out  1  one-cycle pulse: `physical_address` is valid.
- `physical_address`  out  32  translated address.
- `tlb_miss_detected`  out  1  level; high while a miss is outstanding.
- `miss_virtual_address`  out  32  latched faulting VA, stable while `tlb_miss_detected`.
- `tlb_update`  in  1  fill strobe from `tlb_miss`.
- `fill_physical_address`  in  32  physical address for the missed VA; only PPN bits are used.
- `flush`  in  1  invalidate all entries.

## Operation
- Entry = {valid, vpn, ppn}. Hit: valid && vpn == VA[31:12]. At most one entry hits, because fills only occur on a miss.
- FSM states:
  - IDLE: `req_ready`=1. An accepted request with a hit → stay in IDLE; next cycle `resp_valid`=1 and `physical_address`={ppn, VA[11:0]}.
  - An accepted request with a miss → MISS. The VA is latched into `miss_virtual_address`.
  - MISS: `req_ready`=0 and `tlb_miss_detected`=1.
  - On `tlb_update`, write entry[victim_ptr]={1, latched vpn, fill_physical_address[31:12]}, increment victim_ptr mod `ENTRIES`, and return to IDLE. Next cycle `resp_valid`=1, `physical_address`={fill ppn, latched offset}, `tlb_miss_detected`=0.
- Replacement: round-robin victim_ptr. Invalid entries get no priority.
- `tlb_update` in IDLE is ignored: no write, no pointer change.
- `flush`:
  - Clears all valid bits on the next edge; victim_ptr is reset to 0.
  - A request accepted in the same cycle as `flush` uses the pre-flush contents. Its response is still delivered, but no entry survives.
  - In MISS, `flush` does not abort the miss.
  - `flush` and `tlb_update` in the same cycle: all entries are cleared except the newly filled one at index 0, which is valid. victim_ptr becomes 1.
- `physical_address` holds its last value when `resp_valid`=0.

## Timing
- Hit latency: 1 cycle from accept to `resp_valid`.
- Miss: `tlb_miss_detected` rises 1 cycle after accept and falls on the cycle `resp_valid` pulses, i.e. 1 cycle after `tlb_update`.
- Back-to-back hits: one request per cycle.
- Reset (async, `reset`=0):
  - State = IDLE; all entries invalid; victim_ptr=0.
  - `req_ready`=0 while reset is low, and goes to 1 in the first cycle after release.
  - `resp_valid`=0, `tlb_miss_detected`=0, `physical_address`=0, `miss_virtual_address`=0.
- Reset mid-miss: the miss is abandoned, and no response is issued.

## Structure
- Package `tlb_pkg` contains:
  - `tlb_entry_t` struct {valid, vpn[19:0], ppn[19:0]};
  - `tlb_state_e` {IDLE, MISS};
  - constants `PAGE_OFFSET_BITS`, `VPN_BITS`.
- Sub-module `tlb_cam`: combinational compare of a VPN against all entries, producing `hit` and `hit_ppn`.
- The FSM, entry array, and victim pointer live in the top module.

## Test plan
- Reset, then VA 0x00002000 → `tlb_miss_detected`=1 next cycle, `miss_virtual_address`=0x00002000, `req_ready`=0. `tlb_update` with fill 0x00003000 → next cycle `resp_valid`=1, PA=0x00003000, miss cleared.
- After that fill, VA 0x00002ABC → PA 0x00003ABC one cycle later, no miss. Back-to-back requests 0x00002004 and 0x00002008 → PAs 0x00003004 and 0x00003008 on consecutive cycles.
- Fill 5 distinct pages (0x1000..0x5000) with `ENTRIES`=4 → the page 0x1000 entry is evicted. VA 0x00001000 then misses; 0x00005000 hits.
- `tlb_update` pulsed in IDLE → no response and no entry change. Subsequent lookup of an unfilled VA still misses.
- `flush` after fills → VA 0x00002000 misses. Same-cycle `flush` and `tlb_update` in MISS → only the filled page hits afterwards.
- Assert `reset`=0 while in MISS → `tlb_miss_detected`=0 immediately. After release, `req_ready`=1, no stray `resp_valid`, and previous pages miss.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB lookup front-end.
package tlb_pkg;

  localparam int unsigned PAGE_OFFSET_BITS = 12;
  localparam int unsigned VPN_BITS         = 20;

  typedef struct packed {
    logic                valid;
    logic [VPN_BITS-1:0] vpn;
    logic [VPN_BITS-1:0] ppn;
  } tlb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } tlb_state_e;

endpackage

// File: rtl/tlb_cam.sv
// Combinational VPN match against every TLB entry.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 4
) (
  input  tlb_entry_t [ENTRIES-1:0] entries,
  input  logic [VPN_BITS-1:0]      vpn,
  output logic                     hit,
  output logic [VPN_BITS-1:0]      hit_ppn
);

  // Fills only happen on a miss, so at most one entry matches and OR-ing is safe.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (entries[i].valid && (entries[i].vpn == vpn)) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | entries[i].ppn;
      end
    end
  end

endmodule

// File: rtl/tlb_lookup_ctrl.sv
// Fully-associative TLB front-end: one-cycle hits, stall-and-fill on a miss.
module tlb_lookup_ctrl
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES          = 4,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned PAGE_OFFSET_BITS = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] virtual_address,
  output logic                  resp_valid,
  output logic [ADDR_WIDTH-1:0] physical_address,
  output logic                  tlb_miss_detected,
  output logic [ADDR_WIDTH-1:0] miss_virtual_address,
  input  logic                  tlb_update,
  input  logic [ADDR_WIDTH-1:0] fill_physical_address,
  input  logic                  flush
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);

  tlb_state_e                state_q, state_d;
  tlb_entry_t [ENTRIES-1:0]  entries_q, entries_d;
  logic [PTR_W-1:0]          victim_q, victim_d;
  logic                      req_ready_q, req_ready_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [ADDR_WIDTH-1:0]     pa_q, pa_d;
  logic                      miss_q, miss_d;
  logic [ADDR_WIDTH-1:0]     miss_va_q, miss_va_d;

  logic                      hit_c;
  logic [VPN_BITS-1:0]       hit_ppn_c;
  logic [VPN_BITS-1:0]       va_vpn_c;
  logic [PTR_W-1:0]          fill_idx_c;

  assign va_vpn_c = VPN_BITS'(virtual_address >> PAGE_OFFSET_BITS);

  tlb_cam #(.ENTRIES(ENTRIES)) u_cam (
    .entries (entries_q),
    .vpn     (va_vpn_c),
    .hit     (hit_c),
    .hit_ppn (hit_ppn_c)
  );

  always_comb begin
    state_d      = state_q;
    entries_d    = entries_q;
    victim_d     = victim_q;
    resp_valid_d = 1'b0;
    pa_d         = pa_q;
    miss_va_d    = miss_va_q;
    fill_idx_c   = flush ? '0 : victim_q;

    case (state_q)
      IDLE: begin
        // Lookup uses pre-flush contents even when flush is asserted this cycle.
        if (req_valid && req_ready_q) begin
          if (hit_c) begin
            resp_valid_d = 1'b1;
            pa_d = ADDR_WIDTH'({hit_ppn_c, virtual_address[PAGE_OFFSET_BITS-1:0]});
          end else begin
            state_d   = MISS;
            miss_va_d = virtual_address;
          end
        end
      end
      MISS: ;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_d[i].valid = 1'b0;
      end
      victim_d = '0;
    end

    // A fill applied after the flush clear lands in slot 0 and survives.
    if ((state_q == MISS) && tlb_update) begin
      entries_d[fill_idx_c].valid = 1'b1;
      entries_d[fill_idx_c].vpn   = VPN_BITS'(miss_va_q >> PAGE_OFFSET_BITS);
      entries_d[fill_idx_c].ppn   = VPN_BITS'(fill_physical_address >> PAGE_OFFSET_BITS);
      victim_d     = fill_idx_c + PTR_W'(1);
      state_d      = IDLE;
      resp_valid_d = 1'b1;
      pa_d = ADDR_WIDTH'({VPN_BITS'(fill_physical_address >> PAGE_OFFSET_BITS),
                          miss_va_q[PAGE_OFFSET_BITS-1:0]});
    end

    req_ready_d = (state_d == IDLE);
    miss_d      = (state_d == MISS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      entries_q    <= '0;
      victim_q     <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      pa_q         <= '0;
      miss_q       <= 1'b0;
      miss_va_q    <= '0;
    end else begin
      state_q      <= state_d;
      entries_q    <= entries_d;
      victim_q     <= victim_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      pa_q         <= pa_d;
      miss_q       <= miss_d;
      miss_va_q    <= miss_va_d;
    end
  end

  assign req_ready            = req_ready_q;
  assign resp_valid           = resp_valid_q;
  assign physical_address     = pa_q;
  assign tlb_miss_detected    = miss_q;
  assign miss_virtual_address = miss_va_q;

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Directed bench for tlb_lookup_ctrl with a behavioural TLB model checked every cycle.
module tb_tlb_lookup_ctrl;

  localparam int ENT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] virtual_address = '0;
  logic        resp_valid;
  logic [31:0] physical_address;
  logic        tlb_miss_detected;
  logic [31:0] miss_virtual_address;
  logic        tlb_update = 1'b0;
  logic [31:0] fill_physical_address = '0;
  logic        flush = 1'b0;

  int checks = 0;
  int errors = 0;

  tlb_lookup_ctrl #(.ENTRIES(ENT), .ADDR_WIDTH(32), .PAGE_OFFSET_BITS(12)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .virtual_address       (virtual_address),
    .resp_valid            (resp_valid),
    .physical_address      (physical_address),
    .tlb_miss_detected     (tlb_miss_detected),
    .miss_virtual_address  (miss_virtual_address),
    .tlb_update            (tlb_update),
    .fill_physical_address (fill_physical_address),
    .flush                 (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: page table as plain arrays, round-robin slot counter.
  bit          m_val [ENT];
  logic [31:0] m_vpn [ENT];
  logic [31:0] m_ppn [ENT];
  int          m_rr;
  bit          m_pend;
  bit          m_found;
  bit          m_do_fill;
  logic [31:0] m_ppn_hit;
  int          m_slot;
  bit          exp_ready = 1'b0;
  bit          exp_resp  = 1'b0;
  bit          exp_miss  = 1'b0;
  logic [31:0] exp_pa    = '0;
  logic [31:0] exp_mva   = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENT; i++) m_val[i] = 1'b0;
      m_rr = 0; m_pend = 1'b0;
      exp_ready = 1'b0; exp_resp = 1'b0; exp_miss = 1'b0;
      exp_pa = '0; exp_mva = '0;
    end else begin
      exp_resp  = 1'b0;
      m_do_fill = 1'b0;
      if (!m_pend && exp_ready && req_valid) begin
        m_found = 1'b0;
        m_ppn_hit = '0;
        for (int i = 0; i < ENT; i++)
          if (m_val[i] && m_vpn[i] == (virtual_address >> 12)) begin
            m_found = 1'b1; m_ppn_hit = m_ppn[i];
          end
        if (m_found) begin
          exp_resp = 1'b1;
          exp_pa   = (m_ppn_hit << 12) | (virtual_address & 32'hfff);
        end else begin
          m_pend  = 1'b1;
          exp_mva = virtual_address;
        end
      end else if (m_pend && tlb_update) begin
        m_do_fill = 1'b1;
      end
      if (flush) begin
        for (int i = 0; i < ENT; i++) m_val[i] = 1'b0;
        m_rr = 0;
      end
      if (m_do_fill) begin
        m_slot = m_rr;
        m_val[m_slot] = 1'b1;
        m_vpn[m_slot] = exp_mva >> 12;
        m_ppn[m_slot] = fill_physical_address >> 12;
        m_rr     = (m_slot + 1) % ENT;
        m_pend   = 1'b0;
        exp_resp = 1'b1;
        exp_pa   = (fill_physical_address & 32'hffff_f000) | (exp_mva & 32'hfff);
      end
      exp_ready = !m_pend;
      exp_miss  = m_pend;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("cyc_req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("cyc_resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp});
      chk("cyc_miss", {31'd0, tlb_miss_detected}, {31'd0, exp_miss});
      chk("cyc_pa", physical_address, exp_pa);
      if (exp_miss) chk("cyc_miss_va", miss_virtual_address, exp_mva);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] va);
    req_valid = 1'b1;
    virtual_address = va;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic fill(input logic [31:0] pa, input bit with_flush);
    int n;
    n = 0;
    while (!tlb_miss_detected && n < 20) begin
      tick();
      n++;
    end
    if (!tlb_miss_detected) begin
      errors++;
      $display("FAIL fill_wait actual=%0b required=1 (timeout)", tlb_miss_detected);
    end
    tlb_update = 1'b1;
    flush = with_flush;
    fill_physical_address = pa;
    tick();
    tlb_update = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_miss", {31'd0, tlb_miss_detected}, 32'd0);
    chk("rst_pa", physical_address, 32'd0);
    chk("rst_miss_va", miss_virtual_address, 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // First miss and fill.
    req(32'h0000_2000);
    chk("miss1_det", {31'd0, tlb_miss_detected}, 32'd1);
    chk("miss1_va", miss_virtual_address, 32'h0000_2000);
    chk("miss1_ready", {31'd0, req_ready}, 32'd0);
    fill(32'h0000_3000, 1'b0);
    chk("fill1_resp", {31'd0, resp_valid}, 32'd1);
    chk("fill1_pa", physical_address, 32'h0000_3000);
    chk("fill1_miss", {31'd0, tlb_miss_detected}, 32'd0);

    // Hit and back-to-back hits.
    req(32'h0000_2ABC);
    chk("hit_pa", physical_address, 32'h0000_3ABC);
    chk("hit_nomiss", {31'd0, tlb_miss_detected}, 32'd0);
    req_valid = 1'b1;
    virtual_address = 32'h0000_2004;
    tick();
    chk("b2b0_pa", physical_address, 32'h0000_3004);
    virtual_address = 32'h0000_2008;
    tick();
    chk("b2b1_resp", {31'd0, resp_valid}, 32'd1);
    chk("b2b1_pa", physical_address, 32'h0000_3008);
    req_valid = 1'b0;
    tick();

    // Flush removes the mapping.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req(32'h0000_2000);
    chk("flush_miss", {31'd0, tlb_miss_detected}, 32'd1);
    fill(32'h0000_3000, 1'b0);

    // Round-robin eviction over five pages.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      req(32'(p) << 12);
      fill((32'(p) << 12) + 32'h0001_0000, 1'b0);
    end
    req(32'h0000_1000);
    chk("evict_miss", {31'd0, tlb_miss_detected}, 32'd1);
    fill(32'h0001_1000, 1'b0);
    req(32'h0000_5000);
    chk("p5_hit_miss", {31'd0, tlb_miss_detected}, 32'd0);
    chk("p5_hit_pa", physical_address, 32'h0001_5000);

    // tlb_update in IDLE is ignored.
    tlb_update = 1'b1;
    fill_physical_address = 32'h0DEA_D000;
    tick();
    tlb_update = 1'b0;
    chk("idle_upd_resp", {31'd0, resp_valid}, 32'd0);
    tick();
    req(32'h0000_7000);
    chk("unfilled_miss", {31'd0, tlb_miss_detected}, 32'd1);

    // Flush together with fill keeps only the new page.
    fill(32'h0000_8000, 1'b1);
    chk("ffill_pa", physical_address, 32'h0000_8000);
    req(32'h0000_7123);
    chk("ffill_hit_pa", physical_address, 32'h0000_8123);
    req(32'h0000_5000);
    chk("ffill_other_miss", {31'd0, tlb_miss_detected}, 32'd1);
    fill(32'h0001_5000, 1'b0);

    // Request accepted alongside flush still answers from old contents.
    req_valid = 1'b1;
    flush = 1'b1;
    virtual_address = 32'h0000_7004;
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    chk("rflush_resp", {31'd0, resp_valid}, 32'd1);
    chk("rflush_pa", physical_address, 32'h0000_8004);
    req(32'h0000_7004);
    chk("rflush_after_miss", {31'd0, tlb_miss_detected}, 32'd1);
    fill(32'h0000_8000, 1'b0);

    // Reset during an outstanding miss.
    req(32'h0000_9000);
    chk("pre_rst_miss", {31'd0, tlb_miss_detected}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_miss", {31'd0, tlb_miss_detected}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rel2_ready", {31'd0, req_ready}, 32'd1);
    chk("rel2_resp", {31'd0, resp_valid}, 32'd0);
    req(32'h0000_7000);
    chk("post_rst_miss", {31'd0, tlb_miss_detected}, 32'd1);
    fill(32'h0000_8000, 1'b0);
    chk("post_rst_pa", physical_address, 32'h0000_8000);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
